// File: rtl/ram_pipe.sv
// rtl/ram_pipe.sv - pipelined byte-lane-strobed RAM with forwarding and bulk clear
module ram_pipe #(
  parameter int    DATA_WIDTH = 16,
  parameter int    ADDR_WIDTH = 10,
  parameter int    LANE_WIDTH = 8,
  parameter string RAM_TYPE   = "block",
  parameter int    OUT_REG    = 0,
  parameter int    BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             s_ready,
  input  logic                             s_read_req,
  input  logic [ADDR_WIDTH-1:0]            s_read_addr,
  output logic [DATA_WIDTH-1:0]            s_read_data,
  output logic                             s_read_valid,
  input  logic                             s_write_req,
  input  logic [ADDR_WIDTH-1:0]            s_write_addr,
  input  logic [DATA_WIDTH-1:0]            s_write_data,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] s_write_strb,
  input  logic                             s_clear_req
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr;

  logic                    rd_v1, wr_v1;
  logic [ADDR_WIDTH-1:0]   rd_addr1, wr_addr1;
  logic [DATA_WIDTH-1:0]   wr_data1;
  logic [NUM_LANES-1:0]    wr_strb1;

  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    rd_v2;
  logic [DATA_WIDTH-1:0]   rd_d2;

  (* ram_style = RAM_TYPE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Gated by reset so nothing is offered while the block is held in reset.
  assign s_ready = (state_q == IDLE) && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_clear_req) state_d = CLEAR;
      CLEAR:   if (&clr_addr)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_addr <= '0;
    end else if (state_q == CLEAR) begin
      if (&clr_addr) clr_addr <= '0;
      else           clr_addr <= clr_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_v1    <= 1'b0;
      wr_v1    <= 1'b0;
      rd_addr1 <= '0;
      wr_addr1 <= '0;
      wr_data1 <= '0;
      wr_strb1 <= '0;
    end else begin
      rd_v1 <= s_ready && s_read_req;
      wr_v1 <= s_ready && s_write_req;
      if (s_ready && s_read_req) rd_addr1 <= s_read_addr;
      if (s_ready && s_write_req) begin
        wr_addr1 <= s_write_addr;
        wr_data1 <= s_write_data;
        wr_strb1 <= s_write_strb;
      end
    end
  end

  // Clear write comes last so it overrides a stage-1 write to the same word.
  always_ff @(posedge clk) begin
    if (wr_v1) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_strb1[i])
          mem[wr_addr1][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data1[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
    if (state_q == CLEAR) mem[clr_addr] <= '0;
  end

  always_comb begin
    rd_word = mem[rd_addr1];
    if ((BYPASS != 0) && wr_v1 && (wr_addr1 == rd_addr1)) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_strb1[i])
          rd_word[i*LANE_WIDTH +: LANE_WIDTH] = wr_data1[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_v2 <= 1'b0;
      rd_d2 <= '0;
    end else begin
      rd_v2 <= rd_v1;
      if (rd_v1) rd_d2 <= rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  rd_v3;
    logic [DATA_WIDTH-1:0] rd_d3;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_v3 <= 1'b0;
        rd_d3 <= '0;
      end else begin
        rd_v3 <= rd_v2;
        if (rd_v2) rd_d3 <= rd_d2;
      end
    end

    assign s_read_valid = rd_v3;
    assign s_read_data  = rd_d3;
  end else begin : g_no_out_reg
    assign s_read_valid = rd_v2;
    assign s_read_data  = rd_d2;
  end

endmodule

// File: tb/tb_ram_pipe.sv
// tb/tb_ram_pipe.sv - scoreboard bench for ram_pipe, two configurations side by side
module tb_ram_pipe;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_read_req = 1'b0;
  logic [3:0]  s_read_addr = '0;
  logic        s_write_req = 1'b0;
  logic [3:0]  s_write_addr = '0;
  logic [15:0] s_write_data = '0;
  logic [1:0]  s_write_strb = '0;
  logic        s_clear_req = 1'b0;

  logic        ready0, ready1, vld0, vld1;
  logic [15:0] data0, data1;

  logic [15:0] model [16];
  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] last0 = '0;
  logic [15:0] last1 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ram_pipe #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .LANE_WIDTH(8), .RAM_TYPE("block"),
             .OUT_REG(0), .BYPASS(1)) u_dut0 (
    .clk(clk), .reset(reset), .s_ready(ready0),
    .s_read_req(s_read_req), .s_read_addr(s_read_addr),
    .s_read_data(data0), .s_read_valid(vld0),
    .s_write_req(s_write_req), .s_write_addr(s_write_addr),
    .s_write_data(s_write_data), .s_write_strb(s_write_strb),
    .s_clear_req(s_clear_req)
  );

  ram_pipe #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .LANE_WIDTH(8), .RAM_TYPE("block"),
             .OUT_REG(1), .BYPASS(0)) u_dut1 (
    .clk(clk), .reset(reset), .s_ready(ready1),
    .s_read_req(s_read_req), .s_read_addr(s_read_addr),
    .s_read_data(data1), .s_read_valid(vld1),
    .s_write_req(s_write_req), .s_write_addr(s_write_addr),
    .s_write_data(s_write_data), .s_write_strb(s_write_strb),
    .s_clear_req(s_clear_req)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] s);
    logic [15:0] r;
    r = old;
    if (s[0]) r[7:0]  = d[7:0];
    if (s[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // Drive one cycle of requests; expectations are queued only if the request is accepted.
  task automatic drive(input logic rr, input logic [3:0] ra, input logic wr,
                       input logic [3:0] wa, input logic [15:0] wd, input logic [1:0] ws,
                       input logic clr);
    logic [15:0] byp;
    s_read_req = rr;  s_read_addr = ra;
    s_write_req = wr; s_write_addr = wa; s_write_data = wd; s_write_strb = ws;
    s_clear_req = clr;
    if (ready0) begin
      if (rr) begin
        byp = model[ra];
        if (wr && wa == ra) byp = merge(byp, wd, ws);
        q0.push_back('{byp, cyc + 2});
        q1.push_back('{model[ra], cyc + 3});
      end
      if (wr) model[wa] = merge(model[wa], wd, ws);
      if (clr) for (int i = 0; i < 16; i++) model[i] = '0;
    end
    @(negedge clk);
    s_read_req = 1'b0; s_write_req = 1'b0; s_clear_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 4'd0, 0, 4'd0, 16'h0, 2'b00, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) drive(1, 4'(i), 0, 4'd0, 16'h0, 2'b00, 0);
    drain();
  endtask

  always @(negedge clk) begin
    exp_t e0, e1;
    if (!reset) begin
      last0 = '0;
      last1 = '0;
    end else begin
      if (vld0) begin
        if (q0.size() == 0) chk("rd0_unexpected", 1, 0);
        else begin
          e0 = q0.pop_front();
          chk("rd0_data", data0, e0.data);
          chk("rd0_latency", cyc, e0.due);
        end
        last0 = data0;
      end else chk("rd0_hold", data0, last0);
      if (vld1) begin
        if (q1.size() == 0) chk("rd1_unexpected", 1, 0);
        else begin
          e1 = q1.pop_front();
          chk("rd1_data", data1, e1.data);
          chk("rd1_latency", cyc, e1.due);
        end
        last1 = data1;
      end else chk("rd1_hold", data1, last1);
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) model[i] = 'x;

    #3;
    chk("rst_ready0", ready0, 0);
    chk("rst_ready1", ready1, 0);
    chk("rst_valid0", vld0, 0);
    chk("rst_valid1", vld1, 0);
    chk("rst_data0", data0, 0);
    chk("rst_data1", data1, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ready_after_rst0", ready0, 1);
    chk("ready_after_rst1", ready1, 1);
    @(negedge clk);

    // write then read next cycle
    drive(0, 4'd0, 1, 4'd3, 16'hBEEF, 2'b11, 0);
    drive(1, 4'd3, 0, 4'd0, 16'h0, 2'b00, 0);
    // zero-strobe write leaves memory alone
    drive(0, 4'd0, 1, 4'd3, 16'h0000, 2'b00, 0);
    drive(1, 4'd3, 0, 4'd0, 16'h0, 2'b00, 0);
    drain();

    // same-cycle collision: bypass vs pre-write contents
    drive(0, 4'd0, 1, 4'd5, 16'h1234, 2'b11, 0);
    idle(1);
    drive(1, 4'd5, 1, 4'd5, 16'hAB00, 2'b10, 0);
    drive(1, 4'd5, 0, 4'd0, 16'h0, 2'b00, 0);
    drain();

    for (int i = 0; i < 16; i++) drive(0, 4'd0, 1, 4'(i), 16'($urandom), 2'b11, 0);
    for (int i = 0; i < 16; i++) drive(1, 4'(i), 0, 4'd0, 16'h0, 2'b00, 0);
    drain();

    for (int i = 0; i < 32; i++)
      drive(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
            16'($urandom), 2'($urandom), 0);
    drain();

    // bulk clear with a read and write accepted alongside it
    for (int i = 0; i < 16; i++) drive(0, 4'd0, 1, 4'(i), 16'hFFFF, 2'b11, 0);
    drive(1, 4'd0, 1, 4'd15, 16'h1234, 2'b11, 1);
    n = 0;
    while (!ready0 && n < 100) begin
      drive(1, 4'(n), 1, 4'(n), 16'h5555, 2'b11, 1);
      n++;
    end
    chk("clear_busy_cycles", n, 16);
    read_all();

    // reset part way through a clear
    for (int i = 0; i < 16; i++) drive(0, 4'd0, 1, 4'(i), 16'hFFFF, 2'b11, 0);
    drain();
    s_clear_req = 1'b1;
    @(negedge clk);
    s_clear_req = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midclr_ready0", ready0, 0);
    chk("midclr_valid0", vld0, 0);
    chk("midclr_data0", data0, 0);
    chk("midclr_ready1", ready1, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midclr_ready_after", ready0, 1);
    for (int i = 0; i < 7; i++) model[i] = '0;
    @(negedge clk);
    read_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
